// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader: state encoding and debounce defaults.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_X  = 2'd0,
    LOAD_Y  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int OP_W = 2;

  // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for degenerate settings.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises the active-low load button, debounces it and emits a one-cycle
// pulse on each accepted release-to-press transition.
module button_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s1_q, btn_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             pressed_raw_s;

  always_comb begin
    pressed_raw_s = ~btn_s2_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    pulse_d       = 1'b0;
    if (pressed_raw_s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = pressed_raw_s;
        cnt_d   = '0;
        pulse_d = pressed_raw_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Sync flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      btn_s1_q <= btn_n;
      btn_s2_q <= btn_s1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// Loads x, y and operation from slide switches, one field per debounced press.
// Optional OPERAND_CLEAR_EN: clear all fields when leaving READY.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic [OP_W-1:0]   op_sw,
  input  logic              btn_n,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [OP_W-1:0]   operation,
  output logic              valid,
  output logic [1:0]        stage
);

  logic              press_pulse_s;
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
  logic [OP_W-1:0]   op_s1_q, op_s2_q;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .press_pulse(press_pulse_s)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    if (press_pulse_s) begin
      case (state_q)
        LOAD_X: begin
          x_d     = sw_s2_q;
          state_d = LOAD_Y;
        end
        LOAD_Y: begin
          y_d     = sw_s2_q;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = op_s2_q;
          state_d = READY;
        end
        READY: begin
`ifdef OPERAND_CLEAR_EN
          x_d  = '0;
          y_d  = '0;
          op_d = '0;
`endif
          state_d = LOAD_X;
        end
        default: state_d = LOAD_X;
      endcase
    end else begin
      state_d = state_q;
    end
    // Registered from next state so valid rises on the same edge operation loads.
    valid_d = (state_d == READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      op_s1_q <= '0;
      op_s2_q <= '0;
      state_q <= LOAD_X;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      op_s1_q <= op_sw;
      op_s2_q <= op_s1_q;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign operation = op_q;
  assign valid     = valid_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce window.
module tb_operand_loader;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [1:0] op_sw;
  logic       btn_n;
  logic [3:0] x, y;
  logic [1:0] operation;
  logic       valid;
  logic [1:0] stage;

  int checks = 0;
  int errors = 0;

  // Press-level reference model
  int mx, my, mop, mst;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] op;
    int ex, ey, eop, est, ev;
  } vec_t;
  vec_t vecs[4];

  operand_loader #(.DEBOUNCE_CYCLES(DB), .DATA_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .op_sw    (op_sw),
    .btn_n    (btn_n),
    .x        (x),
    .y        (y),
    .operation(operation),
    .valid    (valid),
    .stage    (stage)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int eop,
                         input int est, input int ev);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
    chk({tag, ".operation"}, int'(operation), eop);
    chk({tag, ".stage"}, int'(stage), est);
    chk({tag, ".valid"}, int'(valid), ev);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, mx, my, mop, mst, (mst == 3) ? 1 : 0);
  endtask

  function automatic void model_press(input int s, input int o);
    case (mst)
      0: mx = s;
      1: my = s;
      2: mop = o;
      default: begin
`ifdef OPERAND_CLEAR_EN
        mx = 0; my = 0; mop = 0;
`endif
      end
    endcase
    mst = (mst + 1) % 4;
  endfunction

  function automatic void model_reset();
    mx = 0; my = 0; mop = 0; mst = 0;
  endfunction

  task automatic press(input logic [3:0] s, input logic [1:0] o, input int lo, input int hi);
    sw = s;
    op_sw = o;
    tick(3);
    btn_n = 1'b0;
    tick(lo);
    btn_n = 1'b1;
    tick(hi);
  endtask

  initial begin
    reset = 1'b1;
    sw = 4'd0;
    op_sw = 2'd0;
    btn_n = 1'b1;
    model_reset();
    tick(2);
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(2);

    // Load x=5, then assert reset away from any clock edge
    press(4'd5, 2'd0, 10, 10);
    chk("pre_reset.x", int'(x), 5);
    #3 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    tick(2);

    vecs[0] = '{sw: 4'd5, op: 2'd1, ex: 5, ey: 0, eop: 0, est: 1, ev: 0};
    vecs[1] = '{sw: 4'd9, op: 2'd3, ex: 5, ey: 9, eop: 0, est: 2, ev: 0};
    vecs[2] = '{sw: 4'd0, op: 2'd2, ex: 5, ey: 9, eop: 2, est: 3, ev: 1};
`ifdef OPERAND_CLEAR_EN
    vecs[3] = '{sw: 4'd7, op: 2'd1, ex: 0, ey: 0, eop: 0, est: 0, ev: 0};
`else
    vecs[3] = '{sw: 4'd7, op: 2'd1, ex: 5, ey: 9, eop: 2, est: 0, ev: 0};
`endif
    for (int i = 0; i < 4; i++) begin
      press(vecs[i].sw, vecs[i].op, 10, 10);
      model_press(int'(vecs[i].sw), int'(vecs[i].op));
      chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eop,
              vecs[i].est, vecs[i].ev);
    end

    // Short glitches, including one just under the debounce window
    sw = 4'd12;
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0;
      tick(2);
      btn_n = 1'b1;
      tick(3);
    end
    chk_model("glitch2");
    btn_n = 1'b0;
    tick(DB - 1);
    btn_n = 1'b1;
    tick(6);
    chk_model("glitch3");

    // Long hold captures once only
    sw = 4'd7;
    tick(3);
    btn_n = 1'b0;
    tick(50);
    model_press(7, 0);
    chk_model("hold_mid");
    tick(50);
    chk("hold_end.stage", int'(stage), 1);
    btn_n = 1'b1;
    tick(10);
    chk_model("hold_release");

    // Press of exactly the debounce length is accepted
    press(4'd4, 2'd0, DB, 10);
    model_press(4, 0);
    chk_model("exact_press");

    // Reset in LOAD_OP with a press in progress
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    press(4'd3, 2'd0, 10, 10);
    model_press(3, 0);
    press(4'd4, 2'd0, 10, 10);
    model_press(4, 0);
    chk_model("in_load_op");
    btn_n = 1'b0;
    tick(3);
    #2 reset = 1'b1;
    #1 model_reset();
    chk_model("reset_load_op");
    btn_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    chk_model("after_reset_idle");
    press(4'd6, 2'd0, 10, 10);
    model_press(6, 0);
    chk_model("after_reset_press");

    // Randomized presses and glitches against the model
    for (int i = 0; i < 30; i++) begin
      logic [3:0] rs;
      logic [1:0] ro;
      rs = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        sw = rs;
        op_sw = ro;
        btn_n = 1'b0;
        tick($urandom_range(1, DB - 1));
        btn_n = 1'b1;
        tick(5);
      end else begin
        press(rs, ro, $urandom_range(DB, 12), 8);
        model_press(int'(rs), int'(ro));
      end
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
